// File: rtl/psum_drain_collector.sv
// Bottom-edge psum collector: sums NUM_PASSES beats per column, buffers finished
// column vectors in a small FIFO and streams them out one column per beat.
module psum_drain_collector #(
  parameter int PE_WIDTH   = 4,
  parameter int NUM_COLS   = 3,
  parameter int ACC_WIDTH  = 16,
  parameter int NUM_PASSES = 3,
  parameter int NUM_GROUPS = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PE_WIDTH-1:0]  psum_IN [NUM_COLS],
  input  logic                 psum_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [COL_W-1:0]     out_col,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int GRP_W  = $clog2(NUM_GROUPS + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NUM_GROUPS - 1);
  localparam logic [GRP_W-1:0]  GRP_ALL   = GRP_W'(NUM_GROUPS);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t state, state_nxt;

  logic [PASS_W-1:0]    pass_cnt;
  logic [GRP_W-1:0]     grp_cnt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [COL_W-1:0]     col_idx;
  logic [ACC_WIDTH-1:0] acc [NUM_COLS];
  logic [ACC_WIDTH-1:0] sum [NUM_COLS];
  logic [ACC_WIDTH-1:0] mem [FIFO_DEPTH][NUM_COLS];

  logic beat, last_pass, push, push_ok, hs, pop, done_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign beat      = (state == ACCUM) && psum_valid;
  assign last_pass = (pass_cnt == PASS_LAST);
  assign hs        = out_valid && out_ready;
  assign pop       = hs && (col_idx == COL_LAST);
  assign push      = beat && last_pass;
  // A full FIFO still accepts the push when its head leaves on the same edge.
  assign push_ok   = push && ((count < CNT_FULL) || pop);

  always_comb begin
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      sum[c] = ACC_WIDTH'(psum_IN[c]);
      if (pass_cnt != '0) sum[c] = acc[c] + ACC_WIDTH'(psum_IN[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (push && (grp_cnt == GRP_LAST)) state_nxt = DRAIN;
      DRAIN: begin
        if ((count == '0) && !hs) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt <= '0;
      grp_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      col_idx  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned c = 0; c < NUM_COLS; c++) acc[c] <= '0;
    end else begin
      done <= done_nxt;
      if ((state == IDLE) && start) begin
        pass_cnt <= '0;
        grp_cnt  <= '0;
        overflow <= 1'b0;
      end
      if (beat) begin
        for (int unsigned c = 0; c < NUM_COLS; c++) acc[c] <= sum[c];
        pass_cnt <= last_pass ? '0 : pass_cnt + 1'b1;
        if (last_pass) grp_cnt <= grp_cnt + 1'b1;
      end
      if (push && !push_ok) overflow <= 1'b1;
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (hs) col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage only; occupancy is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_ok)
      for (int unsigned c = 0; c < NUM_COLS; c++) mem[wr_ptr][c] <= sum[c];
  end

  assign out_valid = (count != '0);
  assign out_col   = col_idx;
  assign out_data  = out_valid ? mem[rd_ptr][col_idx] : '0;
  assign out_last  = out_valid && (col_idx == COL_LAST) && (grp_cnt == GRP_ALL)
                     && (count == CNT_W'(1));
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_psum_drain_collector.sv
// Bench for psum_drain_collector: table-driven tile, hand sequences for corner
// cases and random tiles, all checked against a queue-based behavioural model.
module tb_psum_drain_collector;

  localparam int PW = 4;
  localparam int NC = 3;
  localparam int AW = 5;
  localparam int NP = 3;
  localparam int NG = 3;
  localparam int FD = 2;

  logic          clk, rst, start, psum_valid, out_ready;
  logic [PW-1:0] psum_IN [NC];
  logic [AW-1:0] out_data;
  logic [1:0]    out_col;
  logic          out_valid, out_last, busy, done, overflow;

  psum_drain_collector #(
    .PE_WIDTH(PW), .NUM_COLS(NC), .ACC_WIDTH(AW),
    .NUM_PASSES(NP), .NUM_GROUPS(NG), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .psum_IN(psum_IN),
    .psum_valid(psum_valid), .out_data(out_data), .out_col(out_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 collecting, 2 draining.
  typedef logic [NC-1:0][AW-1:0] vec_t;
  vec_t mq[$];
  int   ph, mpass, mgrp, mcol;
  int   macc [NC];
  bit   movf, mdone;

  int   cap_d[$], cap_c[$], cap_l[$];

  typedef struct packed {
    logic [11:0]      b0, b1, b2;
    logic [NC*AW-1:0] e;
  } row_t;
  row_t tbl [3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; mpass = 0; mgrp = 0; mcol = 0; movf = 0; mdone = 0;
    for (int c = 0; c < NC; c++) macc[c] = 0;
    mq.delete();
  endtask

  task automatic model_step(input bit st, input bit v, input int p [NC], input bit rdy);
    int   sz;
    bit   hs, pop, comp;
    vec_t nv;
    sz = mq.size();
    hs = (sz > 0) && rdy;
    pop = hs && (mcol == NC - 1);
    comp = 0;
    nv = '0;
    mdone = 0;
    case (ph)
      0: if (st) begin ph = 1; mpass = 0; mgrp = 0; movf = 0; end
      1: if (v) begin
        for (int c = 0; c < NC; c++) begin
          macc[c] = (((mpass == 0) ? 0 : macc[c]) + p[c]) % (1 << AW);
          nv[c] = AW'(macc[c]);
        end
        if (mpass == NP - 1) begin comp = 1; mpass = 0; mgrp++; end
        else mpass++;
      end
      default: if (sz == 0) begin ph = 0; mdone = 1; end
    endcase
    if (hs) mcol = (mcol == NC - 1) ? 0 : mcol + 1;
    if (pop) void'(mq.pop_front());
    if (comp) begin
      if (sz < FD || pop) mq.push_back(nv);
      else movf = 1;
      if (mgrp == NG) ph = 2;
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = mq.size();
    chk("out_valid", int'(out_valid), int'(sz > 0));
    if (sz > 0) begin
      chk("out_data", int'(out_data), int'(mq[0][mcol]));
      chk("out_col", int'(out_col), mcol);
      chk("out_last", int'(out_last), int'(sz == 1 && mgrp == NG && mcol == NC - 1));
    end else begin
      chk("out_last_idle", int'(out_last), 0);
    end
    chk("busy", int'(busy), int'(ph != 0));
    chk("done", int'(done), int'(mdone));
    chk("overflow", int'(overflow), int'(movf));
  endtask

  task automatic cycle(input bit st, input bit v, input int p0, input int p1, input int p2,
                       input bit rdy);
    int p [NC];
    check_outputs();
    p[0] = p0 & 15; p[1] = p1 & 15; p[2] = p2 & 15;
    start = st; psum_valid = v; out_ready = rdy;
    for (int c = 0; c < NC; c++) psum_IN[c] = PW'(p[c]);
    if (out_valid && rdy) begin
      cap_d.push_back(int'(out_data));
      cap_c.push_back(int'(out_col));
      cap_l.push_back(int'(out_last));
    end
    model_step(st, v, p, rdy);
    @(negedge clk);
  endtask

  task automatic clear_cap();
    cap_d.delete(); cap_c.delete(); cap_l.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && ph != 0; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("tile_idle", int'(busy), 0);
  endtask

  task automatic rand_beats(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      cycle(0, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{b0: 12'h321, b1: 12'h654, b2: 12'h987, e: {5'd18, 5'd15, 5'd12}};
    tbl[1] = '{b0: 12'hFFF, b1: 12'hFFF, b2: 12'hFFF, e: {5'd13, 5'd13, 5'd13}};
    tbl[2] = '{b0: 12'h50A, b1: 12'h1F3, b2: 12'hF28, e: {5'd21, 5'd17, 5'd21}};

    rst = 1'b0; start = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < NC; c++) psum_IN[c] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_col", int'(out_col), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_out_last", int'(out_last), 0);
    rst = 1'b1;

    // Table-driven tile: basic sums, 5-bit wrap, mixed values; streaming ready.
    clear_cap();
    cycle(1, 0, 0, 0, 0, 1);
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < NP; b++) begin
        logic [11:0] w;
        w = (b == 0) ? tbl[g].b0 : (b == 1) ? tbl[g].b1 : tbl[g].b2;
        cycle(0, 1, int'(w[3:0]), int'(w[7:4]), int'(w[11:8]), 1);
      end
    end
    drain();
    chk("tbl_beats", cap_d.size(), 9);
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < NC; c++) begin
        logic [NC*AW-1:0] e;
        e = tbl[g].e;
        if (cap_d.size() > 3 * g + c) begin
          chk("tbl_data", cap_d[3 * g + c], int'(e[AW * c +: AW]));
          chk("tbl_col", cap_c[3 * g + c], c);
          chk("tbl_last", cap_l[3 * g + c], int'(g == 2 && c == 2));
        end
      end
    end

    // Backpressure: third group dropped while FIFO full.
    clear_cap();
    cycle(1, 0, 0, 0, 0, 0);
    rand_beats(9, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_valid_held", int'(out_valid), 1);
    drain();
    chk("ovf_beats", cap_d.size(), 6);
    if (cap_l.size() == 6) chk("ovf_last6", cap_l[5], 1);
    cycle(1, 0, 0, 0, 0, 1);
    chk("ovf_cleared", int'(overflow), 0);
    rand_beats(9, 1);
    drain();

    // Full FIFO push coinciding with the head's final-column pop.
    clear_cap();
    cycle(1, 0, 0, 0, 0, 0);
    rand_beats(6, 0);
    rand_beats(3, 1);
    chk("fullpop_ovf", int'(overflow), 0);
    drain();
    chk("fullpop_beats", cap_d.size(), 9);

    // Random gapped tiles with random backpressure.
    for (int t = 0; t < 4; t++) begin
      cycle(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 400 && ph != 0; i++)
        cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
      cycle(0, 0, 0, 0, 0, 1);
      chk("rand_tile_idle", int'(busy), 0);
    end

    // Reset in the middle of a tile.
    cycle(1, 0, 0, 0, 0, 0);
    rand_beats(4, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    start = 1'b0; psum_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_cap();
    cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, 1, 1, 1);
    drain();
    chk("midrst_beats", cap_d.size(), 9);
    for (int i = 0; i < cap_d.size(); i++) chk("midrst_data", cap_d[i], 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_drain_collector.md
Name: psum_drain_collector

Overview:
- Sits at the bottom edge of the configurable PE array and consumes its per-column psum outputs.
- Accumulates NUM_PASSES consecutive psum beats per column into wide accumulators, one beat per input-channel pass.
- Buffers completed column vectors in a small FIFO and serialises them, one column per beat, onto a valid/ready stream towards the output buffer.
- Signals tile completion and flags any data lost because the array cannot be back-pressured.

Parameters:
- PE_WIDTH, 4: width of each psum lane from the array.
- NUM_COLS, 3: number of array columns, i.e. psum lanes.
- ACC_WIDTH, 16: accumulator and output data width; must be >= PE_WIDTH.
- NUM_PASSES, 3: psum beats summed per output group; must be >= 1.
- NUM_GROUPS, 4: groups per tile; must be >= 1.
- FIFO_DEPTH, 4: number of completed group vectors buffered; must be >= 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: arms the collector for one tile; sampled only in IDLE.
- psum_IN[NUM_COLS], input, PE_WIDTH each: unpacked array of psums from the array's bottom row.
- psum_valid, input, 1: psum_IN carries a valid beat this cycle. There is no ready path back to the array.
- out_data, output, ACC_WIDTH: accumulated value for column out_col.
- out_col, output, $clog2(NUM_COLS) (minimum 1): column index of out_data.
- out_valid, output, 1: stream valid.
- out_ready, input, 1: stream ready.
- out_last, output, 1: high on the final column of the final group of the tile.
- busy, output, 1: high in ACCUM or DRAIN.
- done, output, 1: one-cycle pulse when the tile is fully drained.
- overflow, output, 1: sticky; set when a group is dropped, cleared by an accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. pass_cnt, grp_cnt, FIFO pointers/count, col_idx and all accumulators = 0. out_valid, out_last, busy, done, overflow = 0. out_data and out_col = 0.
- FSM states:
  - IDLE: start=1 -> ACCUM. Clears pass_cnt, grp_cnt, overflow. psum_valid is ignored in IDLE.
  - ACCUM: start is ignored. Each psum_valid beat is zero-extended to ACC_WIDTH.
    - pass_cnt==0: acc[c] loads the beat.
    - pass_cnt>0: acc[c] += beat, modulo 2^ACC_WIDTH (wraps silently).
    - pass_cnt increments per beat. On the beat where pass_cnt==NUM_PASSES-1, the final sum (acc+beat) is pushed into the FIFO at that same clock edge, pass_cnt returns to 0 and grp_cnt increments.
    - When grp_cnt reaches NUM_GROUPS -> DRAIN.
  - DRAIN: psum_valid is ignored. When the FIFO is empty and no handshake occurs this cycle -> done=1 for one cycle, then IDLE.
- Push rule: a push succeeds if FIFO count < FIFO_DEPTH, or if a pop occurs in the same cycle (simultaneous push and pop on a full FIFO is legal). Otherwise the group is dropped, overflow is set, and the group still counts toward grp_cnt.
- Serializer:
  - out_valid = FIFO non-empty. out_data = head[col_idx]. out_col = col_idx.
  - Handshake (out_valid && out_ready): col_idx increments. At col_idx==NUM_COLS-1 the head is popped and col_idx returns to 0.
  - Output is registered-stable: out_data, out_col and out_valid must not change while out_valid=1 and out_ready=0.
- out_last = out_valid && col_idx==NUM_COLS-1 && the head is the tile's final successfully pushed group, i.e. grp_cnt==NUM_GROUPS and FIFO count==1.
- Latency: the group-completing beat at edge t makes out_valid=1 from t+1 (FIFO was empty, registered output).
- If overflow drops the last group(s), done still fires once the FIFO empties. out_last marks the last group actually emitted.
- Reset mid-tile: all state is discarded immediately, with no done pulse.

Test Plan:
- Basic: PE_WIDTH=4, NUM_COLS=3, NUM_PASSES=3, NUM_GROUPS=1, out_ready=1. Drive start, then beats {1,2,3},{4,5,6},{7,8,9} -> outputs 12/col0, 15/col1, 18/col2 on consecutive cycles; out_last on col2; done pulses one cycle after the col2 handshake; busy drops with done.
- Wrap: ACC_WIDTH=5. Three beats of {15,15,15} -> each column emits 45 mod 32 = 13; overflow stays 0.
- Gapped input: NUM_GROUPS=2, with psum_valid deasserted randomly between beats -> still exactly 2 groups (6 output beats), with sums equal to the per-column sum of each 3-beat window.
- Backpressure/overflow: FIFO_DEPTH=2, NUM_GROUPS=3, out_ready=0 until all 9 beats are sent -> third group dropped, overflow=1. Then set out_ready=1 -> exactly 6 beats out, out_last on the 6th, then done. A new start clears overflow.
- Full-FIFO push with simultaneous pop: FIFO holds 2 groups; out_ready held 1 so the col2 pop coincides with the third group's completing beat -> no drop, overflow=0, 9 output beats.
- Reset mid-operation: assert rst low after 4 beats -> out_valid, busy and done are 0 asynchronously. After release, a fresh tile with {1,1,1}x3 produces 3,3,3.
